// File: rtl/mgmt_gpio_blink_checker.sv
// Monitors the management GPIO blink pattern. It synchronises the pad, measures each
// high pulse and reports pass once enough valid blinks are seen, or fail on a glitch or timeout.
module mgmt_gpio_blink_checker #(
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 8,
    parameter int TMR_W          = 16,
    parameter int EXP_BLINKS     = 10,
    parameter int MIN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             core_clk,
    input  logic             core_rstn,
    input  logic             start,
    input  logic             gpio_in,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] blink_count,
    output logic [TMR_W-1:0] high_len
);

    localparam logic [CNT_W-1:0] EXP_VAL      = CNT_W'(EXP_BLINKS);
    localparam logic [TMR_W-1:0] MIN_VAL      = TMR_W'(MIN_WIDTH);
    localparam logic [TMR_W-1:0] TIMEOUT_VAL  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] PULSE_MAX    = '1;
    localparam logic [1:0]       CODE_TIMEOUT = 2'b01;
    localparam logic [1:0]       CODE_GLITCH  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   gpio_s;
    logic                   gpio_d;
    logic                   rise;
    logic                   fall;
    logic [TMR_W-1:0]       pulse_cnt;
    logic [TMR_W-1:0]       timer;
    logic [TMR_W-1:0]       timer_inc;
    logic [CNT_W-1:0]       count_inc;
    logic                   timeout_hit;
    logic                   valid_width;
    logic                   final_blink;

    assign gpio_s      = sync_q[SYNC_STAGES-1];
    assign rise        = gpio_s & ~gpio_d;
    assign fall        = ~gpio_s & gpio_d;
    assign timer_inc   = timer + TMR_W'(1);
    assign count_inc   = blink_count + CNT_W'(1);
    assign timeout_hit = (timer_inc == TIMEOUT_VAL);
    assign valid_width = (pulse_cnt >= MIN_VAL);
    assign final_blink = (count_inc == EXP_VAL);

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            sync_q <= '0;
            gpio_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            gpio_d <= gpio_s;
        end
    end

    // The timer advances in every active state; a completed final blink wins over a
    // coincident timeout, and a glitch on the timeout edge still reports as a glitch.
    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= 2'b00;
            blink_count <= '0;
            high_len    <= '0;
            pulse_cnt   <= '0;
            timer       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        blink_count <= '0;
                        high_len    <= '0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        fail_code   <= 2'b00;
                        timer       <= '0;
                        pulse_cnt   <= '0;
                        busy        <= 1'b1;
                        state       <= gpio_s ? ARM : LOW;
                    end
                end
                ARM: begin
                    timer <= timer_inc;
                    if (timeout_hit) begin
                        fail      <= 1'b1;
                        fail_code <= CODE_TIMEOUT;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else if (!gpio_s) begin
                        state <= LOW;
                    end
                end
                LOW: begin
                    timer <= timer_inc;
                    if (timeout_hit) begin
                        fail      <= 1'b1;
                        fail_code <= CODE_TIMEOUT;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else if (rise) begin
                        pulse_cnt <= TMR_W'(1);
                        state     <= HIGH;
                    end
                end
                HIGH: begin
                    timer <= timer_inc;
                    if (fall) begin
                        high_len <= pulse_cnt;
                        if (valid_width) begin
                            blink_count <= count_inc;
                            if (final_blink) begin
                                pass  <= 1'b1;
                                busy  <= 1'b0;
                                state <= DONE;
                            end else if (timeout_hit) begin
                                fail      <= 1'b1;
                                fail_code <= CODE_TIMEOUT;
                                busy      <= 1'b0;
                                state     <= DONE;
                            end else begin
                                state <= LOW;
                            end
                        end else begin
                            fail      <= 1'b1;
                            fail_code <= CODE_GLITCH;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end
                    end else begin
                        if (gpio_s && (pulse_cnt != PULSE_MAX)) begin
                            pulse_cnt <= pulse_cnt + TMR_W'(1);
                        end
                        if (timeout_hit) begin
                            fail      <= 1'b1;
                            fail_code <= CODE_TIMEOUT;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mgmt_gpio_blink_checker.sv
// Scoreboard bench for mgmt_gpio_blink_checker: every expected output change is queued with
// the cycle it should appear on, then matched against each observed change of the outputs.
module tb_mgmt_gpio_blink_checker;

    localparam int TB_EXP     = 10;
    localparam int TB_MIN     = 4;
    localparam int TB_TIMEOUT = 500;
    localparam int TB_LAT     = 3;

    logic        core_clk = 1'b0;
    logic        core_rstn;
    logic        start;
    logic        gpio_in;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;
    logic [7:0]  blink_count;
    logic [15:0] high_len;

    mgmt_gpio_blink_checker #(
        .SYNC_STAGES   (2),
        .CNT_W         (8),
        .TMR_W         (16),
        .EXP_BLINKS    (TB_EXP),
        .MIN_WIDTH     (TB_MIN),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .core_clk   (core_clk),
        .core_rstn  (core_rstn),
        .start      (start),
        .gpio_in    (gpio_in),
        .busy       (busy),
        .pass       (pass),
        .fail       (fail),
        .fail_code  (fail_code),
        .blink_count(blink_count),
        .high_len   (high_len)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        int cyc;
        int busy;
        int pass;
        int fail;
        int code;
        int count;
        int hlen;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          vec_count = 0;
    int          err_count = 0;
    logic        mon_en = 1'b0;
    logic [28:0] prev_snap = '0;
    logic [28:0] snap;

    int m_busy = 0, m_pass = 0, m_fail = 0, m_code = 0, m_count = 0, m_hlen = 0;
    int m_start = 0;

    always @(posedge core_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vec_count++;
        if (obs !== expv) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge core_clk);
            #1;
        end
    endtask

    task automatic push_exp(input int at);
        exp_t e;
        e.cyc   = at;
        e.busy  = m_busy;
        e.pass  = m_pass;
        e.fail  = m_fail;
        e.code  = m_code;
        e.count = m_count;
        e.hlen  = m_hlen;
        exp_q.push_back(e);
    endtask

    // Outputs only ever move on an expected event, so any change is matched to the queue head.
    always @(negedge core_clk) begin
        exp_t e;
        if (mon_en) begin
            snap = {busy, pass, fail, fail_code, blink_count, high_len};
            if (snap !== prev_snap) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_change", 32'(snap), 32'(prev_snap));
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("busy", 32'(busy), 32'(e.busy));
                    checkOutput("pass", 32'(pass), 32'(e.pass));
                    checkOutput("fail", 32'(fail), 32'(e.fail));
                    checkOutput("fail_code", 32'(fail_code), 32'(e.code));
                    checkOutput("blink_count", 32'(blink_count), 32'(e.count));
                    checkOutput("high_len", 32'(high_len), 32'(e.hlen));
                end
                prev_snap = snap;
            end
        end
    end

    task automatic startCheck();
        int c;
        c = cyc;
        if (m_busy == 0) begin
            m_busy  = 1;
            m_pass  = 0;
            m_fail  = 0;
            m_code  = 0;
            m_count = 0;
            m_hlen  = 0;
            m_start = c + 1;
            push_exp(c + 1);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input int h, input int l);
        int c;
        c = cyc;
        gpio_in = 1'b1;
        if (m_busy != 0) begin
            m_hlen = h;
            if (h >= TB_MIN) begin
                m_count++;
                if (m_count == TB_EXP) begin
                    m_pass = 1;
                    m_busy = 0;
                end
            end else begin
                m_fail = 1;
                m_code = 2;
                m_busy = 0;
            end
            push_exp(c + h + TB_LAT);
        end
        tick(h);
        gpio_in = 1'b0;
        tick(l);
    endtask

    task automatic resetPulse();
        int c;
        c = cyc;
        core_rstn = 1'b0;
        gpio_in   = 1'b0;
        m_busy = 0; m_pass = 0; m_fail = 0; m_code = 0; m_count = 0; m_hlen = 0;
        push_exp(c + 1);
        tick(1);
        core_rstn = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        checkOutput(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        core_rstn = 1'b0;
        start     = 1'b0;
        gpio_in   = 1'b0;
        tick(3);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pass", 32'(pass), 32'd0);
        checkOutput("reset_fail", 32'(fail), 32'd0);
        checkOutput("reset_code", 32'(fail_code), 32'd0);
        checkOutput("reset_count", 32'(blink_count), 32'd0);
        checkOutput("reset_hlen", 32'(high_len), 32'd0);
        mon_en    = 1'b1;
        core_rstn = 1'b1;
        tick(2);

        // ten clean 20/20 blinks reach pass
        startCheck();
        repeat (10) applyStimulus(20, 20);
        drain("drain_pass_run");

        // a 2-cycle pulse after three blinks is a glitch
        startCheck();
        repeat (3) applyStimulus(20, 20);
        applyStimulus(2, 20);
        drain("drain_glitch_run");

        // three blinks then silence until the timeout
        startCheck();
        repeat (3) applyStimulus(20, 20);
        m_fail = 1;
        m_code = 1;
        m_busy = 0;
        push_exp(m_start + TB_TIMEOUT);
        while (cyc < m_start + TB_TIMEOUT + 10) tick(1);
        drain("drain_timeout_run");

        // a pulse already high at start must not count
        gpio_in = 1'b1;
        tick(5);
        startCheck();
        tick(29);
        gpio_in = 1'b0;
        tick(20);
        repeat (10) applyStimulus(20, 20);
        drain("drain_arm_run");

        // reset in the middle of a high pulse
        startCheck();
        repeat (5) applyStimulus(20, 20);
        gpio_in = 1'b1;
        tick(10);
        resetPulse();
        tick(10);
        drain("drain_reset");

        // fresh run counts from zero; a start while busy is ignored
        startCheck();
        repeat (4) applyStimulus(20, 20);
        startCheck();
        repeat (6) applyStimulus(20, 20);
        drain("drain_busy_start_run");

        // start from DONE clears pass and rearms
        startCheck();
        applyStimulus(20, 20);
        drain("drain_rearm_run");
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
